// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Types and constants shared by the 2-D DCT blocks: the row and column 1-D DCT
// engines, the transpose buffer and the quantiser.
//   DCT_N   block dimension (8x8 blocks)
//   DCT_DW  coefficient width used through the DCT datapath
//   coef_t  one signed coefficient
//   vec8_t  one row or column of a block
//   idx_inc wrap-around increment for 0..7 row/column indices
// ---------------------------------------------------------------------------
package dct_pkg;

   localparam int DCT_N  = 8;
   localparam int DCT_DW = 32;

   typedef logic signed [DCT_DW-1:0] coef_t;
   typedef coef_t vec8_t [DCT_N];

   // Row/column indices are 3 bits wide, so the natural overflow gives mod 8.
   function automatic logic [2:0] idx_inc(input logic [2:0] idx);
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/dct8_tbuf_bank.sv
// ---------------------------------------------------------------------------
// dct8_tbuf_bank
// One 8x8 coefficient store of the ping-pong transpose buffer. Rows are
// written whole; columns are read whole through a combinational mux.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears storage)
//   we           write enable for the row on wr_data
//   wr_row       row index being written
//   wr_data      8 coefficients, element C goes to column C
//   rd_col       column index being read
//   rd_data      8 coefficients, element K is row K of column rd_col
// ---------------------------------------------------------------------------
module dct8_tbuf_bank
   import dct_pkg::*;
#(
   parameter int DW = DCT_DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [2:0]           wr_row,
   input  logic signed [DW-1:0] wr_data [DCT_N],
   input  logic [2:0]           rd_col,
   output logic signed [DW-1:0] rd_data [DCT_N]
);

   logic signed [DW-1:0] mem_r [DCT_N][DCT_N];

   // Row write port; reset clears every cell so no stale block survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DCT_N; r++) begin
            for (int c = 0; c < DCT_N; c++) begin
               mem_r[r][c] <= '0;
            end
         end
      end else if (we) begin
         for (int c = 0; c < DCT_N; c++) begin
            mem_r[wr_row][c] <= wr_data[c];
         end
      end
   end

   // Column read port: picks column rd_col out of every row.
   always_comb begin
      for (int k = 0; k < DCT_N; k++) begin
         rd_data[k] = mem_r[k][rd_col];
      end
   end

endmodule

// File: rtl/dct8_transpose_buf.sv
// ---------------------------------------------------------------------------
// dct8_transpose_buf
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass 1-D DCT
// engines. A block enters as 8 rows and leaves as 8 columns; one bank fills
// while the other drains, so one row in and one column out per clock.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   row handshake; in0..in7 are columns 0..7 of the row
//   out_valid / out_ready column handshake; out0..out7 are rows 0..7
//   out_last              marks column 7 of a block
// Coefficients pass through bit-exact.
// ---------------------------------------------------------------------------
module dct8_transpose_buf
   import dct_pkg::*;
#(
   parameter int DW = DCT_DW,
   parameter int N  = DCT_N
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in0,
   input  logic signed [DW-1:0] in1,
   input  logic signed [DW-1:0] in2,
   input  logic signed [DW-1:0] in3,
   input  logic signed [DW-1:0] in4,
   input  logic signed [DW-1:0] in5,
   input  logic signed [DW-1:0] in6,
   input  logic signed [DW-1:0] in7,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out0,
   output logic signed [DW-1:0] out1,
   output logic signed [DW-1:0] out2,
   output logic signed [DW-1:0] out3,
   output logic signed [DW-1:0] out4,
   output logic signed [DW-1:0] out5,
   output logic signed [DW-1:0] out6,
   output logic signed [DW-1:0] out7,
   output logic                 out_last
);

   // The index counters and the bank array are built for 8x8 only.
   if (N != DCT_N) begin : g_bad_n
      $error("dct8_transpose_buf: N must be 8");
   end

   logic                 wr_bank_r;
   logic                 rd_bank_r;
   logic [2:0]           wr_row_r;
   logic [2:0]           rd_col_r;
   logic [1:0]           full_r;
   logic [1:0]           full_nxt_s;
   logic                 accept_s;
   logic                 xfer_s;
   logic                 we0_s;
   logic                 we1_s;
   logic signed [DW-1:0] wr_vec_s  [DCT_N];
   logic signed [DW-1:0] rd0_vec_s [DCT_N];
   logic signed [DW-1:0] rd1_vec_s [DCT_N];
   logic signed [DW-1:0] rd_vec_s  [DCT_N];

   assign in_ready  = ~full_r[wr_bank_r];
   assign out_valid = full_r[rd_bank_r];
   assign out_last  = out_valid & (rd_col_r == 3'd7);
   assign accept_s  = in_valid & in_ready;
   assign xfer_s    = out_valid & out_ready;
   assign we0_s     = accept_s & (wr_bank_r == 1'b0);
   assign we1_s     = accept_s & (wr_bank_r == 1'b1);

   // Gather the row inputs into a vector for the bank write port.
   always_comb begin
      wr_vec_s[0] = in0;
      wr_vec_s[1] = in1;
      wr_vec_s[2] = in2;
      wr_vec_s[3] = in3;
      wr_vec_s[4] = in4;
      wr_vec_s[5] = in5;
      wr_vec_s[6] = in6;
      wr_vec_s[7] = in7;
   end

   dct8_tbuf_bank #(.DW(DW)) u_bank0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we0_s),
      .wr_row  (wr_row_r),
      .wr_data (wr_vec_s),
      .rd_col  (rd_col_r),
      .rd_data (rd0_vec_s)
   );

   dct8_tbuf_bank #(.DW(DW)) u_bank1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we1_s),
      .wr_row  (wr_row_r),
      .wr_data (wr_vec_s),
      .rd_col  (rd_col_r),
      .rd_data (rd1_vec_s)
   );

   // Output bank mux; the column index is shared, only the bank differs.
   always_comb begin
      for (int k = 0; k < DCT_N; k++) begin
         rd_vec_s[k] = rd_bank_r ? rd1_vec_s[k] : rd0_vec_s[k];
      end
   end

   assign out0 = rd_vec_s[0];
   assign out1 = rd_vec_s[1];
   assign out2 = rd_vec_s[2];
   assign out3 = rd_vec_s[3];
   assign out4 = rd_vec_s[4];
   assign out5 = rd_vec_s[5];
   assign out6 = rd_vec_s[6];
   assign out7 = rd_vec_s[7];

   // Next full flags. A completing write and a completing read always hit
   // different banks (the write bank is never full), so both apply.
   always_comb begin
      full_nxt_s = full_r;
      if (accept_s && (wr_row_r == 3'd7)) begin
         full_nxt_s[wr_bank_r] = 1'b1;
      end else begin
         full_nxt_s = full_nxt_s;
      end
      if (xfer_s && (rd_col_r == 3'd7)) begin
         full_nxt_s[rd_bank_r] = 1'b0;
      end else begin
         full_nxt_s = full_nxt_s;
      end
   end

   // Write-side row counter and bank select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_row_r  <= 3'd0;
         wr_bank_r <= 1'b0;
      end else if (accept_s) begin
         wr_row_r <= idx_inc(wr_row_r);
         if (wr_row_r == 3'd7) begin
            wr_bank_r <= ~wr_bank_r;
         end
      end
   end

   // Read-side column counter and bank select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_col_r  <= 3'd0;
         rd_bank_r <= 1'b0;
      end else if (xfer_s) begin
         rd_col_r <= idx_inc(rd_col_r);
         if (rd_col_r == 3'd7) begin
            rd_bank_r <= ~rd_bank_r;
         end
      end
   end

   // Bank occupancy flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_r <= 2'b00;
      end else begin
         full_r <= full_nxt_s;
      end
   end

endmodule

// File: tb/tb_dct8_transpose_buf.sv
// ---------------------------------------------------------------------------
// tb_dct8_transpose_buf
// Self-checking bench: every accepted row goes into a reference block; when a
// block completes, its 8 transposed columns are queued and compared against
// the DUT columns as they transfer.
// ---------------------------------------------------------------------------
module tb_dct8_transpose_buf;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;
   logic out_last;
   logic signed [31:0] in0, in1, in2, in3, in4, in5, in6, in7;
   logic signed [31:0] out0, out1, out2, out3, out4, out5, out6, out7;

   dct8_transpose_buf #(.DW(32), .N(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .in4(in4), .in5(in5), .in6(in6), .in7(in7),
      .out_valid(out_valid), .out_ready(out_ready),
      .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .out4(out4), .out5(out5), .out6(out6), .out7(out7),
      .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   logic [255:0] stim_q [$];
   logic [255:0] exp_q  [$];
   bit           last_q [$];
   logic [255:0] model_blk [8];
   int           mrow = 0;
   int           exp_cols = 0, got_cols = 0;
   int           exp_blocks = 0, got_last = 0;
   bit           prev_hold = 1'b0;
   logic [255:0] prev_obs = '0;
   bit           lat_pend = 1'b0;
   bit           chk_ir = 1'b0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] out_bus();
      return {out7, out6, out5, out4, out3, out2, out1, out0};
   endfunction

   // One clock cycle: drive at the falling edge, check, then log what the
   // coming rising edge will accept or transfer.
   task automatic step(input bit v, input bit rdy);
      logic [255:0] obs;
      logic [255:0] col;
      bit           acc, xf, lst;
      @(negedge clk);
      in_valid  = v && (stim_q.size() > 0);
      if (in_valid) {in7, in6, in5, in4, in3, in2, in1, in0} = stim_q[0];
      out_ready = rdy;
      obs = out_bus();
      if (prev_hold) begin
         chk("hold_valid", 256'(out_valid), 256'(1'b1));
         chk("hold_data", obs, prev_obs);
      end
      if (lat_pend) chk("latency", 256'(out_valid), 256'(1'b1));
      lat_pend = 1'b0;
      if (!out_valid) chk("last_idle", 256'(out_last), 256'(1'b0));
      if (chk_ir) chk("in_ready_stream", 256'(in_ready), 256'(1'b1));
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (xf) begin
         if (exp_q.size() == 0) begin
            chk("extra_col", 256'(1'b1), 256'(1'b0));
         end else begin
            col = exp_q.pop_front();
            lst = last_q.pop_front();
            chk("col", obs, col);
            chk("last", 256'(out_last), 256'(lst));
         end
         got_cols++;
         if (out_last) got_last++;
      end
      prev_hold = out_valid && !out_ready;
      prev_obs  = obs;
      if (acc) begin
         model_blk[mrow] = stim_q.pop_front();
         if (mrow == 7) begin
            for (int c = 0; c < 8; c++) begin
               for (int k = 0; k < 8; k++) col[k*32 +: 32] = model_blk[k][c*32 +: 32];
               exp_q.push_back(col);
               last_q.push_back(c == 7);
            end
            exp_cols += 8;
            exp_blocks++;
            lat_pend = 1'b1;
            mrow = 0;
         end else begin
            mrow++;
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() > 0 || stim_q.size() > 0) && n < 20000) begin
         step(1'b1, 1'b1);
         n++;
      end
      if (n >= 20000) chk("drain_timeout", 256'(1'b0), 256'(1'b1));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
   endtask

   task automatic push_plain_block(input int base);
      logic [255:0] r;
      for (int row = 0; row < 8; row++) begin
         for (int c = 0; c < 8; c++) r[c*32 +: 32] = 32'(base + row*8 + c);
         stim_q.push_back(r);
      end
   endtask

   initial begin
      logic [255:0] r;
      logic [255:0] zero_bus;
      int n;
      zero_bus = '0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      {in7, in6, in5, in4, in3, in2, in1, in0} = '0;
      #12;
      chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
      chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
      chk("rst_out_last", 256'(out_last), 256'(1'b0));
      chk("rst_out_data", out_bus(), zero_bus);
      @(negedge clk); rst_n = 1'b1;

      // Single block, inC = r*8+C.
      push_plain_block(0);
      drain();

      // Four back-to-back blocks, continuous valid/ready.
      for (int b = 0; b < 4; b++) push_plain_block(1000 + b*100);
      chk_ir = 1'b1;
      for (int i = 0; i < 32; i++) step(1'b1, 1'b1);
      chk_ir = 1'b0;
      drain();

      // Backpressure: 16 rows fill both banks, more rows are held off.
      for (int b = 0; b < 3; b++) push_plain_block(5000 + b*100);
      for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
      chk("bp_in_ready_low", 256'(in_ready), 256'(1'b0));
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("bp_still_low", 256'(in_ready), 256'(1'b0));
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
      chk("bp_low_before_col7", 256'(in_ready), 256'(1'b0));
      @(posedge clk); #1;
      chk("bp_in_ready_rise", 256'(in_ready), 256'(1'b1));
      drain();

      // Signed extremes at distinct positions.
      for (int row = 0; row < 8; row++) begin
         for (int c = 0; c < 8; c++) begin
            if (c == row)          r[c*32 +: 32] = 32'sh8000_0000;
            else if (c == 7 - row) r[c*32 +: 32] = 32'sh7FFF_FFFF;
            else if (row == 0)     r[c*32 +: 32] = -32'sd1;
            else                   r[c*32 +: 32] = -32'(row*8 + c + 1);
         end
         stim_q.push_back(r);
      end
      drain();

      // Reset while block 0 drains at column 3 and 5 rows of block 1 are in.
      push_plain_block(7000);
      for (int i = 0; i < 5; i++) stim_q.push_back({8{32'h0BAD_0000 + 32'(i)}});
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 256'(in_ready), 256'(1'b1));
      chk("mid_rst_out_valid", 256'(out_valid), 256'(1'b0));
      chk("mid_rst_out_last", 256'(out_last), 256'(1'b0));
      chk("mid_rst_out_data", out_bus(), zero_bus);
      for (int i = 0; i < last_q.size(); i++) if (last_q[i]) exp_blocks--;
      exp_cols -= exp_q.size();
      exp_q.delete(); last_q.delete(); stim_q.delete();
      mrow = 0; prev_hold = 1'b0; lat_pend = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      push_plain_block(9000);
      drain();

      // Random stress, 200 blocks.
      for (int b = 0; b < 200; b++) begin
         for (int row = 0; row < 8; row++) begin
            for (int c = 0; c < 8; c++) r[c*32 +: 32] = $urandom();
            stim_q.push_back(r);
         end
      end
      n = 0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && n < 40000) begin
         step(1'($urandom_range(1)), 1'($urandom_range(1)));
         n++;
      end
      if (n >= 40000) chk("stress_timeout", 256'(1'b0), 256'(1'b1));
      drain();

      chk("col_count", 256'(got_cols), 256'(exp_cols));
      chk("last_count", 256'(got_last), 256'(exp_blocks));
      chk("queue_empty", 256'(exp_q.size()), 256'(0));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
